// File: rtl/mole_link_pkg.sv
// mole_link_pkg
//   Shared constants, types and helpers for the mole link host.
//   - ASCII bytes exchanged with the remote board (hit, start, position base)
//   - mole count and one-hot mole vector type
//   - TX sequencer state encoding
//   - helpers: position-byte decode and 8-bit saturating increment
package mole_link_pkg;

    localparam int MOLE_COUNT = 5;

    localparam logic [7:0] CH_HIT      = 8'h48;  // 'H'
    localparam logic [7:0] CH_START    = 8'h53;  // 'S'
    localparam logic [7:0] CH_POS_BASE = 8'h30;  // '0' = mole 0

    // Outstanding 'H' bytes are held in a 2-bit saturating counter.
    localparam logic [1:0] HIT_PEND_MAX = 2'd3;

    // Cycles TX_ACK waits for tx_busy before assuming the handshake was lost.
    localparam int ACK_WAIT_CYCLES = 4;

    typedef logic [MOLE_COUNT-1:0] mole_vec_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_ACK   = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_t;

    // True for the position bytes '0'..'4'.
    function automatic logic is_pos_byte(input logic [7:0] b);
        return (b >= CH_POS_BASE) && (b < (CH_POS_BASE + 8'(MOLE_COUNT)));
    endfunction

    // One-hot mole vector for a position byte (only meaningful when is_pos_byte).
    function automatic mole_vec_t pos_onehot(input logic [7:0] b);
        logic [7:0] idx;
        idx = b - CH_POS_BASE;
        return mole_vec_t'(1) << idx[2:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mole_tx_sequencer.sv
// mole_tx_sequencer
//   Turns pending-byte requests into single uart_tx launches.
//   Ports:
//     clock, reset      system clock, async active-low reset
//     start_pend        an 'S' byte is waiting (has priority)
//     hit_pend          at least one 'H' byte is waiting
//     tx_busy           uart_tx is shifting a byte
//     tx_start          one-cycle launch pulse for uart_tx
//     tx_data           byte for uart_tx, held until the next launch is loaded
//     grant_start       one-cycle: the 'S' request has been consumed
//     grant_hit         one-cycle: one 'H' request has been consumed
module mole_tx_sequencer
    import mole_link_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start_pend,
    input  logic       hit_pend,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       grant_start,
    output logic       grant_hit
);

    tx_state_t  state;
    tx_state_t  state_nx;
    logic       sel_start;   // byte currently loaded is 'S' (else 'H')
    logic [1:0] ack_cnt;     // cycles spent in TX_ACK without tx_busy
    logic       load;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            TX_IDLE: begin
                if ((start_pend || hit_pend) && !tx_busy) begin
                    state_nx = TX_SEND;
                end
            end
            TX_SEND: begin
                state_nx = TX_ACK;
            end
            TX_ACK: begin
                if (tx_busy) begin
                    state_nx = TX_DRAIN;
                end else if (ack_cnt == 2'(ACK_WAIT_CYCLES - 1)) begin
                    // uart_tx never acknowledged; don't wedge the link.
                    state_nx = TX_IDLE;
                end
            end
            TX_DRAIN: begin
                if (!tx_busy) begin
                    state_nx = TX_IDLE;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

    always_comb begin
        load        = (state == TX_IDLE) && (start_pend || hit_pend) && !tx_busy;
        tx_start    = (state == TX_SEND);
        grant_start = (state == TX_SEND) && sel_start;
        grant_hit   = (state == TX_SEND) && !sel_start;
    end

    // tx_data is loaded one cycle ahead of tx_start and only reloaded from
    // TX_IDLE, so it is stable for the whole uart_tx transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_data   <= 8'h00;
            sel_start <= 1'b0;
            ack_cnt   <= 2'd0;
        end else begin
            if (load) begin
                tx_data   <= start_pend ? CH_START : CH_HIT;
                sel_start <= start_pend;
            end
            if (state == TX_ACK) begin
                ack_cnt <= ack_cnt + 2'd1;
            end else begin
                ack_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/mole_link_host.sv
// mole_link_host
//   Host side of the whack-a-mole serial link. Mirrors the remote mole
//   position received over UART, scores local button presses against it,
//   and reports hits ('H') and game starts ('S') back over UART.
//   Ports:
//     clock, reset          system clock (100 MHz), async active-low reset
//     rx_data, rx_ready     received byte and its one-cycle strobe
//     tx_busy               uart_tx is shifting a byte
//     start_req             one-cycle start pulse
//     press[4:0]            one-cycle mole-button pulses
//     tx_start, tx_data     launch pulse and byte for uart_tx
//     remote_mole[4:0]      one-hot mirrored mole, 0 when none
//     mole_valid            position is current and not timed out
//     hit_count, miss_count saturating scores since the last start
//     proto_err             one-cycle pulse on an unrecognised rx byte
module mole_link_host
    import mole_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_busy,
    input  logic                  start_req,
    input  logic [MOLE_COUNT-1:0] press,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [MOLE_COUNT-1:0] remote_mole,
    output logic                  mole_valid,
    output logic [7:0]            hit_count,
    output logic [7:0]            miss_count,
    output logic                  proto_err
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            armed;
    logic [TO_W-1:0] timeout_cnt;
    logic            start_pend;
    logic [1:0]      hit_pend;
    logic            grant_start;
    logic            grant_hit;

    logic            pos_byte;
    logic            bad_byte;
    logic            is_hit;
    logic            hit_queue;
    logic            timed_out;
    logic [1:0]      hit_pend_left;

    // Presses are judged against the registered mole, so a byte arriving in
    // the same cycle only affects the next press.
    assign pos_byte      = rx_ready && is_pos_byte(rx_data);
    assign bad_byte      = rx_ready && !is_pos_byte(rx_data);
    assign is_hit        = (|(press & remote_mole)) && armed && mole_valid;
    assign hit_queue     = is_hit && !start_req;
    assign timed_out     = mole_valid && (timeout_cnt == TO_LAST);
    assign hit_pend_left = hit_pend - {1'b0, grant_hit};

    // Decode, scoring and timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remote_mole <= '0;
            mole_valid  <= 1'b0;
            armed       <= 1'b0;
            hit_count   <= 8'h00;
            miss_count  <= 8'h00;
            proto_err   <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            proto_err <= bad_byte && !start_req;
            if (start_req) begin
                remote_mole <= '0;
                mole_valid  <= 1'b0;
                armed       <= 1'b0;
                hit_count   <= 8'h00;
                miss_count  <= 8'h00;
                timeout_cnt <= '0;
            end else begin
                if (is_hit) begin
                    hit_count <= sat_inc8(hit_count);
                    armed     <= 1'b0;
                end else if (|press) begin
                    miss_count <= sat_inc8(miss_count);
                end
                // A position byte in the same cycle as a hit re-arms: the
                // later assignment to armed below takes effect.
                if (pos_byte) begin
                    remote_mole <= pos_onehot(rx_data);
                    mole_valid  <= 1'b1;
                    armed       <= 1'b1;
                    timeout_cnt <= '0;
                end else if (timed_out) begin
                    remote_mole <= '0;
                    mole_valid  <= 1'b0;
                    armed       <= 1'b0;
                    timeout_cnt <= '0;
                end else if (mole_valid) begin
                    timeout_cnt <= timeout_cnt + TO_W'(1);
                end
            end
        end
    end

    // Pending TX requests. The grant is retired before a same-cycle hit is
    // added, so a full counter that is being drained still accepts the hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_pend <= 1'b0;
            hit_pend   <= 2'd0;
        end else begin
            if (start_req) begin
                start_pend <= 1'b1;
            end else if (grant_start) begin
                start_pend <= 1'b0;
            end
            if (hit_queue && (hit_pend_left != HIT_PEND_MAX)) begin
                hit_pend <= hit_pend_left + 2'd1;
            end else begin
                hit_pend <= hit_pend_left;
            end
        end
    end

    mole_tx_sequencer u_tx_seq (
        .clock       (clock),
        .reset       (reset),
        .start_pend  (start_pend),
        .hit_pend    (hit_pend != 2'd0),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant_start (grant_start),
        .grant_hit   (grant_hit)
    );

endmodule

// File: tb/tb_mole_link_host.sv
// tb_mole_link_host
//   Randomised and directed stimulus against a game-level reference model.
//   The driver updates the model as it issues each input cycle and queues the
//   bytes the host owes the link; a separate monitor compares the DUT outputs
//   every cycle and pops the byte queue whenever tx_start is seen.
module tb_mole_link_host;

    localparam int T = 16;  // timeout used for this bench

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       tx_busy = 1'b0;
    logic       start_req = 1'b0;
    logic [4:0] press = 5'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] remote_mole;
    logic       mole_valid;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic       proto_err;

    mole_link_host #(.TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_busy     (tx_busy),
        .start_req   (start_req),
        .press       (press),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .remote_mole (remote_mole),
        .mole_valid  (mole_valid),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .proto_err   (proto_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- reference model (game level) ----------------
    int         m_pos = -1;   // mole index, -1 when no mole
    bit         m_armed = 0;
    int         m_age = 0;    // cycles since the last position byte
    int         m_hits = 0;
    int         m_miss = 0;
    bit         m_perr = 0;
    logic [7:0] exp_q[$];     // bytes owed to the link, in send order

    function automatic int count_h();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i] == 8'h48) n++;
        return n;
    endfunction

    function automatic bit has_s();
        foreach (exp_q[i]) if (exp_q[i] == 8'h53) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pos = -1; m_armed = 0; m_age = 0;
        m_hits = 0; m_miss = 0; m_perr = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit st, input logic [4:0] pr, input bit rr, input logic [7:0] rd);
        bit hit;
        m_perr = 0;
        if (st) begin
            m_hits = 0; m_miss = 0; m_pos = -1; m_armed = 0;
            if (!has_s()) exp_q.push_front(8'h53);  // 'S' overtakes queued hits
        end else begin
            hit = 0;
            if (pr != 0 && m_pos >= 0 && m_armed) hit = pr[m_pos];
            if (hit) begin
                if (m_hits < 255) m_hits++;
                m_armed = 0;
                if (count_h() < 3) exp_q.push_back(8'h48);
            end else if (pr != 0) begin
                if (m_miss < 255) m_miss++;
            end
            if (rr && rd >= 8'h30 && rd <= 8'h34) begin
                m_pos = int'(rd) - 'h30;
                m_armed = 1;
                m_age = 0;
            end else begin
                if (rr) m_perr = 1;
                if (m_pos >= 0) begin
                    m_age++;
                    if (m_age == T) begin
                        m_pos = -1;
                        m_armed = 0;
                    end
                end
            end
        end
    endtask

    // One input cycle: drive at the falling edge, model the following rising edge.
    task automatic drive(input bit st, input logic [4:0] pr, input bit rr, input logic [7:0] rd);
        @(negedge clock);
        start_req = st; press = pr; rx_ready = rr; rx_data = rd;
        if (reset) model_step(st, pr, rr, rd);
        else model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'b0, 0, 8'h00);
    endtask

    // ---------------- uart_tx stand-in ----------------
    bit busy_hold = 0;   // force tx_busy high
    bit uart_mute = 0;   // ignore tx_start (lost handshake)
    int busy_len  = 4;
    int busy_left = 0;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            busy_left = 0;
            tx_busy   = 1'b0;
        end else begin
            tx_busy = busy_hold || (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (tx_start && !uart_mute) busy_left = busy_len;
        end
    end

    // ---------------- monitor ----------------
    int         sent_h = 0;
    int         sent_s = 0;
    int         start_cyc = -100;
    bit         prev_start = 0;
    bit         in_flight = 0;
    bit         seen_busy = 0;
    logic [7:0] held_data = 8'h00;

    initial begin
        logic [4:0] em;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                prev_start = 0; in_flight = 0; seen_busy = 0;
                continue;
            end
            em = 5'b0;
            if (m_pos >= 0) em[m_pos] = 1'b1;
            check("remote_mole", remote_mole, em);
            check("mole_valid", mole_valid, (m_pos >= 0) ? 1 : 0);
            check("hit_count", hit_count, m_hits);
            check("miss_count", miss_count, m_miss);
            check("proto_err", proto_err, m_perr);
            if (tx_start) begin
                check("tx_start_back_to_back", prev_start, 0);
                check("tx_start_while_busy", tx_busy, 0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got tx_start with tx_data=0x%02h, expected none, cycle %0d",
                             tx_data, cyc);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
                if (tx_data == 8'h48) sent_h++;
                if (tx_data == 8'h53) sent_s++;
                start_cyc = cyc;
                held_data = tx_data;
                in_flight = 1;
                seen_busy = 0;
            end else if (in_flight) begin
                check("tx_data_stable", tx_data, held_data);
                if (tx_busy) seen_busy = 1;
                else if (seen_busy) in_flight = 0;
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || tx_busy) && k < 400) begin
            idle(1);
            k++;
        end
        idle(6);
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, h0, n, press_cyc;
        logic [4:0] pr;
        logic [7:0] rd;
        bit st, rr;

        #2 reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_remote_mole", remote_mole, 0);
        check("rst_mole_valid", mole_valid, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_proto_err", proto_err, 0);
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Position 2 then a hit on it; the 'H' launches two cycles after the press.
        h0 = sent_h;
        drive(0, 5'b0, 1, 8'h32);
        drive(0, 5'b00100, 0, 8'h00);
        press_cyc = cyc;
        idle(1);
        check("t1_remote_mole", remote_mole, 5'b00100);
        check("t1_hit_count", hit_count, 1);
        idle(4);
        check("t1_hit_latency", start_cyc - press_cyc, 2);
        drain("t1_drain");
        check("t1_h_sent", sent_h - h0, 1);

        // Wrong mole, hit, then the same mole again (disarmed -> miss).
        drive(1, 5'b0, 0, 8'h00);
        drain("t2_start_drain");
        h0 = sent_h;
        drive(0, 5'b0, 1, 8'h31);
        drive(0, 5'b00100, 0, 8'h00);
        drive(0, 5'b00010, 0, 8'h00);
        drive(0, 5'b00010, 0, 8'h00);
        idle(1);
        check("t2_hit_count", hit_count, 1);
        check("t2_miss_count", miss_count, 2);
        drain("t2_drain");
        check("t2_h_sent", sent_h - h0, 1);

        // Start in the same cycle as a would-be hit: start wins.
        s0 = sent_s; h0 = sent_h;
        drive(0, 5'b0, 1, 8'h33);
        drive(1, 5'b01000, 0, 8'h00);
        idle(1);
        check("t3_hit_count", hit_count, 0);
        drain("t3_drain");
        check("t3_s_sent", sent_s - s0, 1);
        check("t3_h_sent", sent_h - h0, 0);

        // Four hits while uart_tx is busy: only three 'H' are kept. Then saturate the scores.
        h0 = sent_h;
        busy_hold = 1;
        idle(2);
        for (int k = 0; k < 4; k++) begin
            drive(0, 5'b0, 1, 8'h30 + 8'(k));
            drive(0, 5'(1) << k, 0, 8'h00);
        end
        idle(1);
        check("t4_hit_count", hit_count, 4);
        for (int k = 0; k < 260; k++) begin
            drive(0, 5'b0, 1, 8'h30 + 8'(k % 5));
            drive(0, 5'(1) << (k % 5), 0, 8'h00);
        end
        idle(1);
        check("t4_hit_sat", hit_count, 255);
        for (int k = 0; k < 260; k++) drive(0, 5'b11111, 0, 8'h00);
        idle(1);
        check("t4_miss_sat", miss_count, 255);
        busy_hold = 0;
        drain("t4_drain");
        check("t4_h_sent", sent_h - h0, 3);

        // Unknown byte pulses proto_err once and keeps the mole; then the timeout.
        drive(0, 5'b0, 1, 8'h30);
        drive(0, 5'b0, 1, 8'h7A);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            if (proto_err) n++;
        end
        check("t5_proto_pulses", n, 1);
        check("t5_mole_kept", remote_mole, 5'b00001);
        drive(0, 5'b0, 1, 8'h30);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (mole_valid) n++;
        end
        check("t5_timeout_len", n, T);

        // Lost handshake: uart_tx never raises busy, the sequencer must recover.
        h0 = sent_h;
        uart_mute = 1;
        drive(0, 5'b0, 1, 8'h32);
        drive(0, 5'b00100, 0, 8'h00);
        idle(10);
        drive(0, 5'b0, 1, 8'h33);
        drive(0, 5'b01000, 0, 8'h00);
        idle(10);
        uart_mute = 0;
        drain("t6_drain");
        check("t6_h_sent", sent_h - h0, 2);

        // Randomised play.
        for (int k = 0; k < 2500; k++) begin
            busy_len = $urandom_range(1, 6);
            st = (exp_q.size() == 0) && ($urandom_range(0, 63) == 0);
            rr = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) rd = 8'($urandom_range(0, 255));
            else rd = 8'h30 + 8'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0: pr = (m_pos >= 0) ? (5'(1) << m_pos) : 5'($urandom_range(1, 31));
                1: pr = 5'($urandom_range(1, 31));
                default: pr = 5'b0;
            endcase
            drive(st, pr, rr, rd);
        end
        busy_len = 4;
        drain("rand_drain");

        // Reset while a byte is draining and another 'H' is pending.
        busy_len = 12;
        drive(0, 5'b0, 1, 8'h30);
        drive(0, 5'b00001, 0, 8'h00);
        idle(3);
        drive(0, 5'b0, 1, 8'h31);
        drive(0, 5'b00010, 0, 8'h00);
        idle(2);
        check("t8_busy_before_reset", tx_busy, 1);
        h0 = sent_h;
        @(negedge clock);
        reset = 1'b0;
        start_req = 0; press = 0; rx_ready = 0; rx_data = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("t8_rst_tx_start", tx_start, 0);
        end
        check("t8_rst_tx_data", tx_data, 0);
        check("t8_rst_remote_mole", remote_mole, 0);
        check("t8_rst_mole_valid", mole_valid, 0);
        check("t8_rst_hit_count", hit_count, 0);
        check("t8_rst_miss_count", miss_count, 0);
        check("t8_rst_proto_err", proto_err, 0);
        @(negedge clock);
        reset = 1'b1;
        busy_len = 4;
        idle(20);
        check("t8_h_lost", sent_h - h0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
